moving_average_uart_tx: RTL and testbench
=========================================

// Module: moving_average_uart_tx
// PURPOSE
// - Stage directly downstream of the moving-average filter mux. Consumes the registered
//   10-bit filtered sample and its single-cycle output strobe.
// - Buffers samples in a small FIFO and transmits each one on a single pin as a UART-style
//   frame: 1 start bit (0), 10 data bits LSB first, 1 stop bit (1).
// - Lets a slow external host capture filter output without a 10-bit parallel bus.
// PARAMETERS
// - DATA_LEN       10  sample width; also the number of data bits per frame
// - FIFO_AW        2   FIFO address width; depth = 2**FIFO_AW = 4 entries
// - CLKS_PER_BIT   104 clk cycles per serial bit (>=2)
// PORTS
// - clk          in   1         clock; all state updates on rising edge
// - rst_n        in   1         asynchronous, active-low reset
// - data_in      in   DATA_LEN  filtered sample; valid only while strobe_in=1
// - strobe_in    in   1         1-cycle sample-valid pulse from the filter mux
// - clear_ovf    in   1         synchronous clear of the overflow flag
// - tx           out  1         serial output; idles high
// - busy         out  1         1 while the FSM is not IDLE or the FIFO is non-empty
// - overflow     out  1         sticky: a sample was dropped because the FIFO was full
// - fifo_level   out  FIFO_AW+1 current FIFO occupancy, 0..2**FIFO_AW
// BEHAVIOUR
// - Reset (async assert, sync-safe deassert): tx=1, busy=0, overflow=0, fifo_level=0,
//   FSM=IDLE, bit counter=0, baud counter=0.
// - Push: strobe_in=1 and FIFO not full -> data_in is written at that edge.
//   strobe_in=1 with FIFO full and no pop in the same cycle -> sample is dropped and
//   overflow is set.
// - Pop: occurs in the IDLE->START transition. The FIFO head is loaded into the shift
//   register and the read pointer advances.
// - Simultaneous push and pop: both take effect; level is unchanged. When full, this push
//   is accepted (no overflow).
// - overflow: clear_ovf=1 clears it. If clear_ovf and a new overflow event occur in the
//   same cycle, set wins.
// - FSM states:
//   - IDLE: tx=1. If FIFO non-empty -> START (pop).
//   - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
//     After DATA_LEN bits -> STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. Then: FIFO non-empty -> START (pop, no idle gap);
//     otherwise -> IDLE.
// - tx is driven from a register (glitch-free).
// - Latency, empty and idle: strobe_in high in cycle N -> tx falls at edge N+2.
//   Frame length = 12*CLKS_PER_BIT cycles.
// - Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter wraps DATA_LEN-1 -> 0.
//   FIFO pointers wrap modulo depth; full/empty are decided by fifo_level.
// - strobe_in pulses longer than 1 cycle: each high cycle is a separate push. The upstream
//   block guarantees 1-cycle pulses.
// - Reset mid-frame: frame aborted, tx=1 immediately (async), FIFO contents discarded.
// STRUCTURE
// - Shared package moving_average_pkg holds:
//   - typedef tx_state_t {IDLE, START, DATA, STOP}, 2-bit encoding
//   - localparam UART_FRAME_BITS = DATA_LEN + 2
// - One sub-module, moving_average_sync_fifo: params WIDTH, AW; ports push, pop, wdata,
//   rdata, level, full, empty; first-word-fall-through; same clk/rst_n.
// - Top level holds the FSM, baud counter, bit counter, shift register, overflow flag.
// TESTING (CLKS_PER_BIT=4, DATA_LEN=10, FIFO_AW=2)
// - Reset: hold rst_n=0 -> tx=1, busy=0, overflow=0, fifo_level=0. Assert rst_n mid-frame
//   -> tx=1 in the same cycle.
// - Single sample 10'h2A5 with a 1-cycle strobe -> tx low 2 edges later.
//   Bit sequence 0,1,0,1,0,0,1,0,1,0,1,1, each bit 4 cycles; busy falls after 48 cycles.
// - Back-to-back: strobes 10'h001, 10'h3FF two cycles apart -> two frames with no idle
//   cycle between stop and start; fifo_level peaks at 1.
// - Overflow: 6 strobes on consecutive cycles while idle.
//   - 1st sample is popped; the next 4 fill the FIFO; the 6th is dropped -> overflow=1.
//   - Exactly 5 frames are transmitted.
//   - clear_ovf pulse -> overflow=0.
// - Full with simultaneous pop: keep the FIFO full; strobe lands in the STOP->START pop
//   cycle -> accepted, level stays 4, overflow stays 0.
// - Random 200 samples with strobe spacing >= 48 cycles -> a UART monitor decodes every
//   sample bit-exact, in order, with overflow=0.

Source files
------------

// File: rtl/moving_average_pkg.sv
// Shared types and constants for the moving-average UART transmitter slice.
package moving_average_pkg;

    localparam int DATA_LEN        = 10;
    localparam int UART_FRAME_BITS = DATA_LEN + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/moving_average_uart_tx_if.sv
// Sample handshake from the filter mux: a data word qualified by a 1-cycle strobe.
interface moving_average_uart_tx_if #(
    parameter int DATA_LEN = 10
);

    logic [DATA_LEN-1:0] data_in;
    logic                strobe_in;

    modport master (output data_in, output strobe_in);
    modport slave  (input  data_in, input  strobe_in);

endinterface

// File: rtl/moving_average_sync_fifo.sv
// Small first-word-fall-through FIFO; full/empty are derived from the occupancy count.
module moving_average_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam int            DEPTH      = 1 << AW;
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/moving_average_uart_tx.sv
// Buffers filtered samples and serialises each as start + DATA_LEN bits LSB first + stop.
module moving_average_uart_tx #(
    parameter int DATA_LEN     = 10,
    parameter int FIFO_AW      = 2,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                      clk,
    input  logic                      rst_n,
    moving_average_uart_tx_if.slave   sample_if,
    input  logic                      clear_ovf,
    output logic                      tx,
    output logic                      busy,
    output logic                      overflow,
    output logic [FIFO_AW:0]          fifo_level
);

    import moving_average_pkg::*;

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W    = $clog2(DATA_LEN);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_LEN - 1);

    tx_state_t           state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                ovf_q, ovf_d;

    logic                pop;
    logic                baud_end;
    logic [DATA_LEN-1:0] fifo_rdata;
    logic                fifo_full, fifo_empty;

    moving_average_sync_fifo #(
        .WIDTH (DATA_LEN),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sample_if.strobe_in),
        .pop   (pop),
        .wdata (sample_if.data_in),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // tx_d always carries the level of the bit that starts at the next edge.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        baud_end = (baud_q == BAUD_MAX);
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        bit_d   = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A new drop wins over a clear arriving in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (sample_if.strobe_in && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_moving_average_uart_tx.sv
// Directed bench for moving_average_uart_tx with a UART line monitor decoding every frame.
module tb_moving_average_uart_tx;

    localparam int CPB   = 4;
    localparam int DL    = 10;
    localparam int AW    = 2;
    localparam int FRAME = 12 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [AW:0]   fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DL-1:0] mon_q[$];
    int            mon_start[$];
    logic [DL-1:0] exp_q[$];

    moving_average_uart_tx_if #(.DATA_LEN(DL)) sample_if ();

    moving_average_uart_tx #(
        .DATA_LEN     (DL),
        .FIFO_AW      (AW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_if  (sample_if),
        .clear_ovf  (clear_ovf),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DL-1:0] d);
        sample_if.data_in   = d;
        sample_if.strobe_in = 1'b1;
        tick();
        sample_if.strobe_in = 1'b0;
    endtask

    task automatic clearMonitor();
        mon_q.delete();
        mon_start.delete();
    endtask

    // Line monitor: samples mid-bit on the falling clock edge and rebuilds each frame.
    initial begin : monitor
        int            k;
        int            b;
        logic          in_frame;
        logic [DL-1:0] sh;
        k        = 0;
        in_frame = 1'b0;
        sh       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                k        = 0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    k        = 0;
                    mon_start.push_back(cyc);
                end
            end else begin
                k++;
                if (k % CPB == CPB / 2) begin
                    b = k / CPB;
                    if (b == 0) begin
                        checkOutput("mon_start_bit", tx, 0);
                    end else if (b <= DL) begin
                        sh[b-1] = tx;
                    end else begin
                        checkOutput("mon_stop_bit", tx, 1);
                        mon_q.push_back(sh);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [11:0]   seq;
        logic [DL-1:0] d;
        int            peak;

        sample_if.data_in   = '0;
        sample_if.strobe_in = 1'b0;

        // Reset values while rst_n is held low
        #12;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_level", fifo_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Single sample: start bit, 1,0,1,0,0,1,0,1,0,1, stop bit
        clearMonitor();
        seq = 12'b1101_0100_1010;
        applyStimulus(10'h2A5);
        checkOutput("single_level", fifo_level, 1);
        checkOutput("single_tx_before", tx, 1);
        checkOutput("single_busy", busy, 1);
        tick();
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 1) checkOutput($sformatf("single_bit%0d", i), tx, seq[i]);
                tick();
            end
        end
        checkOutput("single_busy_end", busy, 0);
        checkOutput("single_tx_idle", tx, 1);
        checkOutput("single_count", mon_q.size(), 1);
        if (mon_q.size() == 1) checkOutput("single_data", mon_q[0], 10'h2A5);

        // Back-to-back frames with no idle gap
        clearMonitor();
        peak = 0;
        applyStimulus(10'h001);
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        tick();
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        applyStimulus(10'h3FF);
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            tick();
        end
        checkOutput("b2b_peak", peak, 1);
        checkOutput("b2b_count", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            checkOutput("b2b_data0", mon_q[0], 10'h001);
            checkOutput("b2b_data1", mon_q[1], 10'h3FF);
            checkOutput("b2b_gap", mon_start[1] - mon_start[0], FRAME);
        end
        checkOutput("b2b_busy_end", busy, 0);

        // Overflow: six consecutive strobes, the sixth is dropped
        clearMonitor();
        for (int i = 0; i < 6; i++) begin
            sample_if.data_in   = DL'(10'h100 + i);
            sample_if.strobe_in = 1'b1;
            tick();
        end
        sample_if.strobe_in = 1'b0;
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_level", fifo_level, 4);
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);
        repeat (5 * FRAME + 10) tick();
        checkOutput("ovf_count", mon_q.size(), 5);
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            checkOutput($sformatf("ovf_data%0d", i), mon_q[i], 10'h100 + i);
        end
        checkOutput("ovf_busy_end", busy, 0);

        // Full FIFO with a push landing in the STOP->START pop cycle
        clearMonitor();
        for (int i = 0; i < 5; i++) begin
            sample_if.data_in   = DL'(10'h200 + i);
            sample_if.strobe_in = 1'b1;
            tick();
        end
        sample_if.strobe_in = 1'b0;
        checkOutput("full_level", fifo_level, 4);
        repeat (44) tick();
        checkOutput("full_level_prepop", fifo_level, 4);
        applyStimulus(10'h2FF);
        checkOutput("full_level_postpop", fifo_level, 4);
        checkOutput("full_no_ovf", overflow, 0);
        repeat (5 * FRAME + 10) tick();
        checkOutput("full_count", mon_q.size(), 6);
        if (mon_q.size() == 6) begin
            checkOutput("full_first", mon_q[0], 10'h200);
            checkOutput("full_last", mon_q[5], 10'h2FF);
        end
        checkOutput("full_overflow_end", overflow, 0);

        // Reset in the middle of a frame aborts it and discards the FIFO
        applyStimulus(10'h000);
        applyStimulus(10'h155);
        applyStimulus(10'h0AA);
        repeat (10) tick();
        checkOutput("midrst_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx", tx, 1);
        checkOutput("midrst_level", fifo_level, 0);
        checkOutput("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clearMonitor();
        repeat (FRAME + 4) tick();
        checkOutput("midrst_no_frames", mon_q.size(), 0);
        checkOutput("midrst_tx_idle", tx, 1);

        // Random samples with generous spacing
        clearMonitor();
        exp_q.delete();
        for (int n = 0; n < 200; n++) begin
            d = DL'($urandom_range(0, 1023));
            exp_q.push_back(d);
            applyStimulus(d);
            repeat (FRAME + $urandom_range(0, 8)) tick();
        end
        repeat (FRAME + 10) tick();
        checkOutput("rand_count", mon_q.size(), 200);
        for (int n = 0; n < 200 && n < mon_q.size(); n++) begin
            checkOutput($sformatf("rand_data%0d", n), mon_q[n], exp_q[n]);
        end
        checkOutput("rand_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
